bit_serializer: RTL and testbench
=================================

Name: bit_serializer

Overview:
- Upstream feeder for the serial sequence detector. Accepts parallel words over a valid/ready handshake.
- Shifts each word out MSB-first, one bit per clock, on a single-bit stream that drives the detector's serial input `i`.
- A one-word holding register allows back-to-back words to stream with no idle gap, so multi-word patterns and patterns spanning word boundaries reach the detector contiguously.

Parameters:
- WIDTH, 8: word width in bits; legal range 2 to 32.
- IDLE_BIT, 1'b0: value driven on `o` when no word is being shifted.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-low
- din  input  WIDTH  parallel word to serialize
- din_valid  input  1  din holds a word
- din_ready  output  1  block can accept a word this cycle
- o  output  1  serial bit stream, MSB-first; feeds detector `i`
- o_valid  output  1  `o` carries a data bit this cycle
- o_last  output  1  `o` is bit 0 (LSB) of the current word
- busy  output  1  word in shift register or holding register

Behaviour:
- Reset:
  - All state changes only on the rising clk edge.
  - rst low at an edge clears: state to IDLE, shift register, bit counter, holding register, hold_full.
  - Output values after reset: o=IDLE_BIT, o_valid=0, o_last=0, busy=0.
  - din_ready=0 while rst is low.
- din_ready: combinational, equals rst && !hold_full.
- Accept: din_valid && din_ready at an edge. din is sampled only on accept.
- State machine, two states:
  - IDLE:
    - accept loads din into the shift register, sets cnt=WIDTH-1, goes to SHIFT.
  - SHIFT:
    - Each edge shifts left by one and decrements cnt.
    - At the edge where cnt==0 (last bit being presented), the next word is chosen in this priority:
      1. If hold_full: hold moves into the shift register, cnt=WIDTH-1, hold_full clears, stay in SHIFT.
      2. Else if accept at that edge: din loads directly into the shift register, stay in SHIFT.
      3. Else go to IDLE.
    - Accept while cnt!=0 writes din into hold and sets hold_full.
- Outputs (all registered except din_ready):
  - o = shift register MSB while in SHIFT, IDLE_BIT in IDLE.
  - o_valid=1 exactly while in SHIFT.
  - o_last=1 when in SHIFT and cnt==0.
  - busy = (state==SHIFT) || hold_full.
- Latency: a word accepted at edge k presents its MSB on `o` after edge k. Its LSB appears after edge k+WIDTH-1.
- Throughput: with din_valid held high, o_valid stays 1 continuously. Sustained rate is one word per WIDTH cycles.
- din_ready timing:
  - Drops the cycle after a word lands in hold.
  - Returns the cycle after hold transfers to the shift register.
- Simultaneous events:
  - Hold transfer and accept never coincide, because din_ready=0 whenever hold_full.
  - Accept on the last-bit edge with hold empty gives a gapless transition.
- Reset mid-word: the partial word and any held word are discarded. o returns to IDLE_BIT and o_valid to 0 after the reset edge. No bits are emitted after reset until a new accept.
- cnt width: $clog2(WIDTH). No wrap beyond WIDTH-1.
- din is ignored when din_valid=0. No X propagation into o in IDLE.

Test Plan:
1. Reset, then a single word WIDTH=8, din=8'b0110_0110, one-cycle din_valid.
   - o over the next 8 cycles = 0,1,1,0,0,1,1,0 with o_valid=1.
   - o_last=1 on the 8th cycle only.
   - Then o=IDLE_BIT, o_valid=0, busy=0.
   - Detector downstream pulses twice.
2. Back-to-back words, din_valid held, words 8'hA5 then 8'h3C.
   - 16 consecutive o_valid=1 cycles, bits 10100101 00111100.
   - din_ready=0 from cycle 2 until the hold transfer.
   - o_last on cycles 8 and 16.
3. Gapless direct load: second word offered only on the first word's last-bit cycle (hold empty).
   - No o_valid gap between the words.
   - The second word's MSB appears the cycle after the first word's o_last.
4. Boundary-spanning pattern: words 8'b0000_0011 then 8'b0xxx_xxxx (MSB 0).
   - Stream contains ...1,1,0 across the boundary.
   - Detector asserts once.
5. Reset mid-word: rst driven low after 3 bits of 8'hFF, with a second word in hold.
   - After the reset edge: o=0, o_valid=0, busy=0, din_ready=0 while rst low.
   - After release: no stale bits, din_ready=1.
6. WIDTH=4, IDLE_BIT=1, din=4'b0110.
   - Stream 0,1,1,0, then o=1 with o_valid=0 when idle.

Source files
------------

// File: rtl/bit_serializer.sv
// Parallel-to-serial feeder for the sequence detector: accepts words over valid/ready
// and shifts them out MSB-first, with a one-word holding register for gapless streaming.
module bit_serializer #(
  parameter int   WIDTH    = 8,
  parameter logic IDLE_BIT = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             o,
  output logic             o_valid,
  output logic             o_last,
  output logic             busy
);

  localparam int                CNT_W   = $clog2(WIDTH);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] shreg, shreg_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [WIDTH-1:0] hold, hold_nx;
  logic             hold_full, hold_full_nx;
  logic             accept;

  assign din_ready = rst && !hold_full;
  assign accept    = din_valid && din_ready;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the values from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      shreg     <= '0;
      cnt       <= '0;
      hold      <= '0;
      hold_full <= 1'b0;
    end else begin
      state     <= state_nx;
      shreg     <= shreg_nx;
      cnt       <= cnt_nx;
      hold      <= hold_nx;
      hold_full <= hold_full_nx;
    end
  end

  // NOTE: every signal gets its hold-value default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nx     = state;
    shreg_nx     = shreg;
    cnt_nx       = cnt;
    hold_nx      = hold;
    hold_full_nx = hold_full;
    case (state)
      IDLE: begin
        if (accept) begin
          shreg_nx = din;
          cnt_nx   = CNT_MAX;
          state_nx = SHIFT;
        end
      end
      SHIFT: begin
        shreg_nx = {shreg[WIDTH-2:0], 1'b0};
        if (cnt == '0) begin
          // Last bit on the wire: a held word wins, then a direct load, else go idle.
          if (hold_full) begin
            shreg_nx     = hold;
            cnt_nx       = CNT_MAX;
            hold_full_nx = 1'b0;
          end else if (accept) begin
            shreg_nx = din;
            cnt_nx   = CNT_MAX;
          end else begin
            state_nx = IDLE;
          end
        end else begin
          cnt_nx = cnt - 1'b1;
          if (accept) begin
            hold_nx      = din;
            hold_full_nx = 1'b1;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign o       = (state == SHIFT) ? shreg[WIDTH-1] : IDLE_BIT;
  assign o_valid = (state == SHIFT);
  assign o_last  = (state == SHIFT) && (cnt == '0);
  assign busy    = (state == SHIFT) || hold_full;

endmodule

// File: tb/tb_bit_serializer.sv
// Bench for bit_serializer: a bit-queue reference model predicts the serial stream,
// handshake and status outputs; a second instance covers WIDTH=4 with IDLE_BIT=1.
module tb_bit_serializer;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [7:0] din;
  logic       din_valid, din_ready, o, o_valid, o_last, busy;
  logic [3:0] din4;
  logic       din4_valid, din4_ready, o4, o4_valid, o4_last, busy4;

  bit_serializer #(.WIDTH(8), .IDLE_BIT(1'b0)) u_dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(din_ready),
    .o(o), .o_valid(o_valid), .o_last(o_last), .busy(busy)
  );

  bit_serializer #(.WIDTH(4), .IDLE_BIT(1'b1)) u_dut4 (
    .clk(clk), .rst(rst), .din(din4), .din_valid(din4_valid), .din_ready(din4_ready),
    .o(o4), .o_valid(o4_valid), .o_last(o4_last), .busy(busy4)
  );

  // Reference model: the bits still owed to the wire, front element = bit on `o` now.
  // The holding register is full exactly when more than one word's worth is owed.
  typedef struct packed { logic b; logic last; } wbit_t;
  wbit_t exp_q[$];
  logic  stream[$];
  int    n_cmp = 0;
  int    n_bad = 0;
  logic [4:0] obs_vec, exp_vec;

  task automatic advance(input logic v, input logic [7:0] d, output bit acc);
    int n;
    rst = 1'b1; din_valid = v; din = d;
    #1;
    n = exp_q.size();
    if (n > 0) exp_vec = {exp_q[0].b, 1'b1, exp_q[0].last, 1'b1, n <= 8};
    else       exp_vec = 5'b00001;
    obs_vec = {o, o_valid, o_last, busy, din_ready};
    if (o_valid) stream.push_back(o);
    acc = v && (n <= 8);
    @(posedge clk);
    if (n > 0) void'(exp_q.pop_front());
    if (acc) for (int i = 7; i >= 0; i--) exp_q.push_back('{b: d[i], last: (i == 0)});
    #1;
  endtask

  function automatic int count_110();
    int c = 0;
    for (int i = 0; i + 2 < stream.size(); i++)
      if (stream[i] && stream[i+1] && !stream[i+2]) c++;
    return c;
  endfunction

  function automatic logic [15:0] packed_stream();
    logic [15:0] p = '0;
    foreach (stream[i]) p = {p[14:0], stream[i]};
    return p;
  endfunction

  task automatic test_reset();
    rst = 1'b0; din_valid = 1'b1; din = 8'hFF; din4_valid = 1'b0; din4 = 4'h0;
    #1;
    n_cmp++;
    if (din_ready !== 1'b0) begin n_bad++; $display("FAIL reset_ready_low: got %b expected 0", din_ready); end
    @(posedge clk); #1;
    n_cmp++;
    if ({o, o_valid, o_last, busy, din_ready} !== 5'b00000) begin
      n_bad++; $display("FAIL reset_outputs: got %b expected 00000", {o, o_valid, o_last, busy, din_ready});
    end
    n_cmp++;
    if ({o4, o4_valid, o4_last, busy4} !== 4'b1000) begin
      n_bad++; $display("FAIL reset_outputs_w4: got %b expected 1000", {o4, o4_valid, o4_last, busy4});
    end
    @(posedge clk); #1;
    rst = 1'b1; din_valid = 1'b0;
    exp_q.delete();
    #1;
    n_cmp++;
    if (din_ready !== 1'b1) begin n_bad++; $display("FAIL reset_release_ready: got %b expected 1", din_ready); end
  endtask

  task automatic test_single();
    bit acc;
    stream.delete();
    for (int c = 0; c < 12; c++) begin
      advance(c == 0, (c == 0) ? 8'b0110_0110 : 8'($urandom), acc);
      n_cmp++;
      if (obs_vec !== exp_vec) begin
        n_bad++; $display("FAIL single c%0d: o/vld/last/busy/rdy got %b expected %b", c, obs_vec, exp_vec);
      end
    end
    n_cmp++;
    if (stream.size() != 8 || packed_stream() !== 16'h0066) begin
      n_bad++; $display("FAIL single_stream: got %0d bits %h expected 8 bits 66", stream.size(), packed_stream());
    end
    n_cmp++;
    if (count_110() != 2) begin n_bad++; $display("FAIL single_detect: got %0d expected 2", count_110()); end
  endtask

  // Two words; gapless=0 offers the second immediately (goes to hold),
  // gapless=1 offers it only on the first word's last-bit cycle (direct load).
  task automatic run_pair(input string name, input logic [7:0] w0, input logic [7:0] w1,
                          input bit gapless, input int exp_ready_low);
    bit acc;
    int idx = 0, run = 0, max_run = 0, ready_low = 0, lasts = 0;
    logic v;
    logic [7:0] d;
    stream.delete();
    for (int c = 0; c < 24; c++) begin
      v = (idx == 0) || (idx == 1 && (!gapless || exp_q.size() == 1));
      d = (idx == 0) ? w0 : (idx == 1) ? w1 : 8'($urandom);
      advance(v, d, acc);
      if (acc) idx++;
      n_cmp++;
      if (obs_vec !== exp_vec) begin
        n_bad++; $display("FAIL %s c%0d: o/vld/last/busy/rdy got %b expected %b", name, c, obs_vec, exp_vec);
      end
      run = obs_vec[3] ? run + 1 : 0;
      if (run > max_run) max_run = run;
      if (!obs_vec[0]) ready_low++;
      if (obs_vec[2]) lasts++;
    end
    n_cmp++;
    if (max_run != 16 || lasts != 2) begin
      n_bad++; $display("FAIL %s_gapless: run %0d lasts %0d expected run 16 lasts 2", name, max_run, lasts);
    end
    n_cmp++;
    if (ready_low != exp_ready_low) begin
      n_bad++; $display("FAIL %s_ready_low: got %0d cycles expected %0d", name, ready_low, exp_ready_low);
    end
    n_cmp++;
    if (packed_stream() !== {w0, w1} || stream.size() != 16) begin
      n_bad++; $display("FAIL %s_stream: got %h expected %h", name, packed_stream(), {w0, w1});
    end
  endtask

  task automatic test_back_to_back();
    run_pair("back_to_back", 8'hA5, 8'h3C, 1'b0, 7);
  endtask

  task automatic test_gapless_direct();
    run_pair("direct_load", 8'($urandom), 8'($urandom), 1'b1, 0);
  endtask

  task automatic test_span();
    run_pair("span", 8'b0000_0011, 8'b0101_0101, 1'b0, 7);
    n_cmp++;
    if (count_110() != 1 || !(stream[6] && stream[7] && !stream[8])) begin
      n_bad++; $display("FAIL span_detect: got count %0d expected 1 at boundary", count_110());
    end
  endtask

  task automatic test_reset_mid();
    bit acc;
    for (int c = 0; c < 4; c++) begin
      advance(c < 2, (c == 0) ? 8'hFF : 8'($urandom), acc);
      n_cmp++;
      if (obs_vec !== exp_vec) begin
        n_bad++; $display("FAIL reset_mid c%0d: o/vld/last/busy/rdy got %b expected %b", c, obs_vec, exp_vec);
      end
    end
    rst = 1'b0; din_valid = 1'b1; din = 8'($urandom);
    #1;
    n_cmp++;
    if (din_ready !== 1'b0) begin n_bad++; $display("FAIL reset_mid_ready: got %b expected 0", din_ready); end
    @(posedge clk); #1;
    n_cmp++;
    if ({o, o_valid, o_last, busy, din_ready} !== 5'b00000) begin
      n_bad++; $display("FAIL reset_mid_outputs: got %b expected 00000", {o, o_valid, o_last, busy, din_ready});
    end
    @(posedge clk); #1;
    exp_q.delete();
    stream.delete();
    for (int c = 0; c < 10; c++) begin
      advance(1'b0, 8'($urandom), acc);
      n_cmp++;
      if (obs_vec !== exp_vec) begin
        n_bad++; $display("FAIL reset_mid_after c%0d: got %b expected %b", c, obs_vec, exp_vec);
      end
    end
    n_cmp++;
    if (stream.size() != 0) begin n_bad++; $display("FAIL reset_mid_stale: got %0d bits expected 0", stream.size()); end
  endtask

  task automatic test_random();
    bit acc;
    for (int c = 0; c < 600; c++) begin
      advance(c < 580 && $urandom_range(0, 3) != 0, 8'($urandom), acc);
      n_cmp++;
      if (obs_vec !== exp_vec) begin
        n_bad++; $display("FAIL random c%0d: o/vld/last/busy/rdy got %b expected %b", c, obs_vec, exp_vec);
      end
    end
  endtask

  task automatic test_width4();
    logic [3:0] pat = 4'b0110;
    din4 = pat; din4_valid = 1'b1;
    #1;
    n_cmp++;
    if ({o4, o4_valid, din4_ready} !== 3'b101) begin
      n_bad++; $display("FAIL w4_idle: o/vld/rdy got %b expected 101", {o4, o4_valid, din4_ready});
    end
    @(posedge clk); #1;
    din4_valid = 1'b0; din4 = 4'($urandom);
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if ({o4, o4_valid, o4_last} !== {pat[3-i], 1'b1, i == 3}) begin
        n_bad++; $display("FAIL w4_bit%0d: o/vld/last got %b expected %b", i, {o4, o4_valid, o4_last}, {pat[3-i], 1'b1, i == 3});
      end
      @(posedge clk); #1;
    end
    for (int i = 0; i < 2; i++) begin
      n_cmp++;
      if ({o4, o4_valid, o4_last, busy4} !== 4'b1000) begin
        n_bad++; $display("FAIL w4_after%0d: o/vld/last/busy got %b expected 1000", i, {o4, o4_valid, o4_last, busy4});
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_gapless_direct();
    test_span();
    test_reset_mid();
    test_random();
    test_width4();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
